fft_peak_tracker: RTL
=====================

// Module: fft_peak_tracker
// PURPOSE
//  Parametrised successor to the single-peak FFT finder in the mic/FFT chain.
//  - Consumes the magnitude^2 stream of one FFT frame and keeps the NPEAKS largest bins above a threshold.
//  - Bins are restricted to a configurable window.
//  - At frame end, emits the ranked list through a valid/ready stream to the LEDR/LCD display logic.
// PARAMETERS
//  W        34    magnitude^2 width (unsigned)
//  NSAMPLES 1024  FFT length; power of two; bin index width KW = $clog2(NSAMPLES)
//  NPEAKS   4     tracked peaks, 1..8
//  HALF     1     1: ignore bins >= NSAMPLES/2 (real-input mirror); 0: full spectrum
// PORTS
//  clk         in   1   system clock (clk_50 domain)
//  reset_n     in   1   asynchronous active-low reset
//  threshold   in   W   bins with mag <= threshold are ignored; sampled at each sof
//  min_bin     in   KW  bins below min_bin are ignored (DC suppression); sampled at sof
//  mag         in   W   magnitude^2 of the current bin
//  mag_valid   in   1   mag is valid this cycle; no backpressure, every valid beat is consumed
//  mag_sof     in   1   qualifies the first bin (k=0) of a frame; only meaningful with mag_valid
//  out_valid   out  1   result entry available
//  out_ready   in   1   consumer accepts the entry when out_valid && out_ready
//  out_mag     out  W   entry magnitude (0 if empty)
//  out_k       out  KW  entry bin index (0 if empty)
//  out_rank    out  3   0 = largest .. NPEAKS-1
//  out_hit     out  1   1: slot holds a real peak; 0: empty slot
//  out_last    out  1   high on the rank NPEAKS-1 entry
//  drop_count  out  8   frames whose results were discarded; saturates at 255
// BEHAVIOUR
//  Reset
//  - All outputs are 0. The list is emptied. The output FSM is IDLE. The bin counter waits for sof.
//  Collection
//  - Beat with sof: start a new frame. k=0, the list is cleared, and threshold/min_bin are latched.
//  - Beats before the first sof are discarded.
//  - Each beat: the bin is a candidate iff mag > thr_q, k >= min_bin_q, and (HALF==0 or k < NSAMPLES/2).
//  - Insertion: compare against all slots in parallel. A candidate goes above the first slot whose mag is strictly smaller.
//  - Lower slots shift down; the last slot falls off. One insertion per cycle, back-to-back beats allowed.
//  - Ties: the earlier bin keeps the higher rank.
//  - Counter is KW bits. A beat with k == NSAMPLES-1 closes the frame; the counter then waits for the next sof.
//  - sof arriving mid-frame: abort the partial frame (no output, no drop count) and restart at k=0 with this beat.
//  - Non-sof beats after a frame closes and before the next sof are ignored.
//  Result hand-off
//  - On close, the final list (including the closing beat) is copied to the output buffer on the next cycle.
//  - out_valid rises 2 cycles after the closing beat.
//  - If the FSM is not IDLE at copy time, the new list is discarded and drop_count increments.
//  - The buffer being drained is never overwritten.
//  - Collection of the next frame proceeds in parallel with draining; the frame gap may be 0.
//  Output FSM
//  - IDLE -> DRAIN on copy. Entries go out in rank order 0..NPEAKS-1.
//  - rank advances on each out_valid && out_ready.
//  - DRAIN -> IDLE on accepting the out_last entry; out_valid drops in the same cycle.
//  - All NPEAKS entries are always emitted. Empty slots carry out_hit=0, mag=0, k=0.
//  - out_* fields are stable while out_valid && !out_ready (AXI-style hold).
//  Reset mid-operation
//  - Asynchronous clear to the reset state. Any partial frame and pending output are lost.
// STRUCTURE
//  - fft_peak_pkg: peak_entry_t struct {mag, k, hit}, MAX_PEAKS=8, the HALF-window helper function, and the rank width constant.
//  - Sub-module peak_insert_list: NPEAKS-deep sorted register list with parallel compare, clear and insert. It holds no control logic.
//  - Top-level logic: sof/counter tracking, candidate qualification, output buffer, and the IDLE/DRAIN FSM.
// TESTING
//  - Single tone: NSAMPLES=1024, thr=100, min_bin=1. mag = 5000 at k=37, else 10.
//    -> rank0 = (5000, 37, hit=1); ranks 1-3 hit=0; out_last on rank 3; out_valid 2 clk after k=1023.
//  - Ordering and ties: mags 300@k5, 900@k9, 300@k12, 700@k40, 50@k60, thr=100.
//    -> ranks = (900,9), (700,40), (300,5), (300,12).
//  - Window: HALF=1, min_bin=2, 9999 at k=0 and k=600, 200 at k=3.
//    -> rank0 = (200,3); k=0 and k=600 are never reported.
//  - Backpressure/drop: hold out_ready=0 over two back-to-back frames.
//    -> first frame's entries are held stable; drop_count = 1.
//    -> after release, exactly 4 entries and then out_valid=0.
//  - Aborted frame: sof at beat 500 of a frame.
//    -> no output for the partial frame; the next full frame reports correctly with drop_count unchanged.
//  - Async reset: assert reset_n=0 mid-DRAIN between edges.
//    -> out_valid=0 and drop_count=0 immediately.
//    -> beats before the next sof produce nothing.

Source files
------------

// File: rtl/fft_peak_pkg.sv
// fft_peak_pkg: shared entry type, limits and bin-window helper for the FFT peak tracker
package fft_peak_pkg;
  localparam int MAX_PEAKS = 8;
  localparam int RANK_W = $clog2(MAX_PEAKS);
  localparam int MAG_W = 34;
  localparam int BIN_W = 10;
  typedef struct packed {
    logic [MAG_W-1:0] mag;
    logic [BIN_W-1:0] k;
    logic hit;
  } peak_entry_t;
  function automatic logic in_window(input int k, input int nsamples, input int half);
    return half == 0 || k < nsamples / 2;
  endfunction
endpackage

// File: rtl/peak_insert_list.sv
// peak_insert_list: descending sorted register list with parallel compare, clear and single insert
module peak_insert_list
  import fft_peak_pkg::*;
#(
  parameter int W = 34,
  parameter int KW = 10,
  parameter int N = 4
) (
  input logic clk,
  input logic reset_n,
  input logic clr,
  input logic ins,
  input logic [W-1:0] ins_mag,
  input logic [KW-1:0] ins_k,
  output peak_entry_t list [N]
);
  peak_entry_t cur [N];
  peak_entry_t nxt [N];
  peak_entry_t new_e;
  logic [N-1:0] gt;
  assign new_e = '{mag: MAG_W'(ins_mag), k: BIN_W'(ins_k), hit: 1'b1};
  for (genvar i = 0; i < N; i++) begin : g_slot
    assign cur[i] = clr ? '0 : list[i];
    assign gt[i] = ins && ins_mag > W'(cur[i].mag);
    if (i == 0) begin : g_head
      assign nxt[i] = gt[i] ? new_e : cur[i];
    end else begin : g_tail
      assign nxt[i] = !gt[i] ? cur[i] : gt[i-1] ? cur[i-1] : new_e;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) list <= '{default: '0};
    else if (clr || ins) list <= nxt;
endmodule

// File: rtl/fft_peak_tracker.sv
// fft_peak_tracker: keeps the NPEAKS largest in-window bins of each FFT frame and streams them out ranked
module fft_peak_tracker
  import fft_peak_pkg::*;
#(
  parameter int W = 34,
  parameter int NSAMPLES = 1024,
  parameter int NPEAKS = 4,
  parameter int HALF = 1,
  localparam int KW = $clog2(NSAMPLES)
) (
  input logic clk,
  input logic reset_n,
  input logic [W-1:0] threshold,
  input logic [KW-1:0] min_bin,
  input logic [W-1:0] mag,
  input logic mag_valid,
  input logic mag_sof,
  output logic out_valid,
  input logic out_ready,
  output logic [W-1:0] out_mag,
  output logic [KW-1:0] out_k,
  output logic [RANK_W-1:0] out_rank,
  output logic out_hit,
  output logic out_last,
  output logic [7:0] drop_count
);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state, state_nxt;
  logic active, take, cand, close, close_q;
  logic [KW-1:0] k, cur_k, min_q, min_b;
  logic [W-1:0] thr_q, thr;
  logic [RANK_W-1:0] rank;
  peak_entry_t list [NPEAKS];
  peak_entry_t obuf [MAX_PEAKS];
  peak_entry_t cur_e;
  always_comb begin
    take = mag_valid && (mag_sof || active);
    cur_k = mag_sof ? '0 : k;
    thr = mag_sof ? threshold : thr_q;
    min_b = mag_sof ? min_bin : min_q;
    cand = take && mag > thr && cur_k >= min_b && in_window(int'(cur_k), NSAMPLES, HALF);
    close = take && &cur_k;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      active <= 1'b0;
      k <= '0;
      thr_q <= '0;
      min_q <= '0;
      close_q <= 1'b0;
    end else begin
      close_q <= close;
      if (take) begin
        active <= !close;
        k <= cur_k + 1'b1;
      end
      if (mag_valid && mag_sof) begin
        thr_q <= threshold;
        min_q <= min_bin;
      end
    end
  peak_insert_list #(.W(W), .KW(KW), .N(NPEAKS)) u_list (
    .clk(clk),
    .reset_n(reset_n),
    .clr(mag_valid && mag_sof),
    .ins(cand),
    .ins_mag(mag),
    .ins_k(cur_k),
    .list(list)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      rank <= '0;
      drop_count <= '0;
      obuf <= '{default: '0};
    end else begin
      state <= state_nxt;
      if (close_q && state == IDLE) for (int i = 0; i < NPEAKS; i++) obuf[i] <= list[i];
      if (close_q && state != IDLE && drop_count != 8'hff) drop_count <= drop_count + 1'b1;
      if (out_valid && out_ready) rank <= out_last ? '0 : rank + 1'b1;
    end
  always_comb begin
    cur_e = obuf[rank];
    out_valid = state == DRAIN;
    out_last = out_valid && rank == RANK_W'(NPEAKS - 1);
    out_mag = out_valid ? W'(cur_e.mag) : '0;
    out_k = out_valid ? KW'(cur_e.k) : '0;
    out_hit = out_valid && cur_e.hit;
    out_rank = rank;
    state_nxt = state == IDLE ? (close_q ? DRAIN : IDLE) : (out_ready && out_last ? IDLE : DRAIN);
  end
endmodule
